// File: rtl/psg_bus_sequencer.sv
// Sole TurboSound PSG bus master: arbitrates CPU port writes/reads and player register
// writes, sequencing player writes so the CPU-visible chip select and latched addresses survive.
module psg_bus_sequencer #(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned SKIP_REDUNDANT = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CPU_ADDR_WR,
  input  logic       CPU_DATA_WR,
  input  logic       CPU_RD,
  input  logic [7:0] CPU_DI,
  output logic       CPU_WAIT,
  input  logic       PL_REQ,
  input  logic       PL_CHIP,
  input  logic [3:0] PL_REG,
  input  logic [7:0] PL_VAL,
  output logic       PL_ACK,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DO,
  output logic       BUSY,
  output logic       OVERRUN,
  output logic       SEL_SHADOW
);

  typedef enum logic [2:0] {StIdle, StOp, StGap, StRead, StDone} state_e;
  // Identifies the bus op most recently issued, so the gap end knows what follows.
  typedef enum logic [2:0] {SeqCpu, SeqSel, SeqAdr, SeqDat, SeqRadr, SeqRsel} seq_e;

  localparam logic [2:0] GapLoad = 3'(GAP_CYCLES - 1);
  localparam bit         Skip    = (SKIP_REDUNDANT != 0);

  state_e          state_q, state_d;
  seq_e            seq_q, seq_d;
  logic [2:0]      gap_q, gap_d;
  logic            pend_vld_q, pend_vld_d;
  logic            pend_is_data_q, pend_is_data_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            pl_chip_q, pl_chip_d;
  logic [3:0]      pl_reg_q, pl_reg_d;
  logic [7:0]      pl_val_q, pl_val_d;
  logic            sel_done_q, sel_done_d;
  logic            sel_q, sel_d;
  logic [1:0][7:0] addr_shadow_q, addr_shadow_d;
  logic            bdir_q, bdir_d;
  logic            bc_q, bc_d;
  logic [7:0]      do_q, do_d;
  logic            wait_q, wait_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic       arb;
  logic       pend_issue;
  logic       op_en;
  logic       op_addr;
  logic [7:0] op_val;
  seq_e       op_seq;
  logic       radr_needed;

  assign radr_needed = !(Skip && (addr_shadow_q[pl_chip_q] == {4'h0, pl_reg_q}));

  always_comb begin
    state_d        = state_q;
    seq_d          = seq_q;
    gap_d          = gap_q;
    pend_vld_d     = pend_vld_q;
    pend_is_data_d = pend_is_data_q;
    pend_data_d    = pend_data_q;
    pl_chip_d      = pl_chip_q;
    pl_reg_d       = pl_reg_q;
    pl_val_d       = pl_val_q;
    sel_done_d     = sel_done_q;
    sel_d          = sel_q;
    addr_shadow_d  = addr_shadow_q;
    bdir_d         = 1'b0;
    bc_d           = 1'b0;
    do_d           = do_q;
    overrun_d      = overrun_q;
    arb            = 1'b0;
    pend_issue     = 1'b0;
    op_en          = 1'b0;
    op_addr        = 1'b0;
    op_val         = 8'h00;
    op_seq         = seq_q;

    unique case (state_q)
      StIdle: arb = 1'b1;
      StOp: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
      StGap: begin
        if (gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else begin
          unique case (seq_q)
            SeqCpu: arb = 1'b1;
            SeqSel: begin
              op_en   = 1'b1;
              op_addr = 1'b1;
              op_val  = {4'h0, pl_reg_q};
              op_seq  = SeqAdr;
            end
            SeqAdr: begin
              op_en  = 1'b1;
              op_val = pl_val_q;
              op_seq = SeqDat;
            end
            SeqDat: begin
              if (radr_needed) begin
                op_en   = 1'b1;
                op_addr = 1'b1;
                op_val  = addr_shadow_q[pl_chip_q];
                op_seq  = SeqRadr;
              end else if (sel_done_q) begin
                op_en   = 1'b1;
                op_addr = 1'b1;
                op_val  = {7'h7F, sel_q};
                op_seq  = SeqRsel;
              end else begin
                state_d = StDone;
              end
            end
            SeqRadr: begin
              if (sel_done_q) begin
                op_en   = 1'b1;
                op_addr = 1'b1;
                op_val  = {7'h7F, sel_q};
                op_seq  = SeqRsel;
              end else begin
                state_d = StDone;
              end
            end
            default: state_d = StDone;
          endcase
        end
      end
      StRead: begin
        if (CPU_RD) bc_d = 1'b1;
        else        state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Arbitration runs in IDLE and also at the end of a CPU op's gap, so back-to-back
    // CPU ops are spaced by exactly one op plus the gap.
    if (arb) begin
      state_d = StIdle;
      if (pend_vld_q) begin
        pend_issue = 1'b1;
        op_en      = 1'b1;
        op_addr    = !pend_is_data_q;
        op_val     = pend_data_q;
        op_seq     = SeqCpu;
        if (!pend_is_data_q) begin
          if (pend_data_q[7:1] == 7'h7F) sel_d = pend_data_q[0];
          else                           addr_shadow_d[sel_q] = pend_data_q;
        end
      end else if (CPU_RD) begin
        state_d = StRead;
        bc_d    = 1'b1;
      end else if (PL_REQ) begin
        pl_chip_d  = PL_CHIP;
        pl_reg_d   = PL_REG;
        pl_val_d   = PL_VAL;
        sel_done_d = !(Skip && (PL_CHIP == sel_q));
        op_en      = 1'b1;
        op_addr    = 1'b1;
        if (sel_done_d) begin
          op_val = {7'h7F, PL_CHIP};
          op_seq = SeqSel;
        end else begin
          op_val = {4'h0, PL_REG};
          op_seq = SeqAdr;
        end
      end
    end

    if (op_en) begin
      state_d = StOp;
      seq_d   = op_seq;
      bdir_d  = 1'b1;
      bc_d    = op_addr;
      do_d    = op_val;
    end

    // A fresh strobe beats the clear of an op issued in the same cycle.
    if (CPU_ADDR_WR || CPU_DATA_WR) begin
      pend_vld_d     = 1'b1;
      pend_is_data_d = !CPU_ADDR_WR;
      pend_data_d    = CPU_DI;
      if ((pend_vld_q && !pend_issue) || (CPU_ADDR_WR && CPU_DATA_WR)) overrun_d = 1'b1;
    end else if (pend_issue) begin
      pend_vld_d = 1'b0;
    end

    wait_d = CPU_RD && (state_d != StRead);
    ack_d  = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= StIdle;
      seq_q          <= SeqCpu;
      gap_q          <= 3'd0;
      pend_vld_q     <= 1'b0;
      pend_is_data_q <= 1'b0;
      pend_data_q    <= 8'h00;
      pl_chip_q      <= 1'b0;
      pl_reg_q       <= 4'h0;
      pl_val_q       <= 8'h00;
      sel_done_q     <= 1'b0;
      sel_q          <= 1'b1;
      addr_shadow_q  <= '0;
      bdir_q         <= 1'b0;
      bc_q           <= 1'b0;
      do_q           <= 8'h00;
      wait_q         <= 1'b0;
      ack_q          <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      gap_q          <= gap_d;
      pend_vld_q     <= pend_vld_d;
      pend_is_data_q <= pend_is_data_d;
      pend_data_q    <= pend_data_d;
      pl_chip_q      <= pl_chip_d;
      pl_reg_q       <= pl_reg_d;
      pl_val_q       <= pl_val_d;
      sel_done_q     <= sel_done_d;
      sel_q          <= sel_d;
      addr_shadow_q  <= addr_shadow_d;
      bdir_q         <= bdir_d;
      bc_q           <= bc_d;
      do_q           <= do_d;
      wait_q         <= wait_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign CPU_WAIT   = wait_q;
  assign PL_ACK     = ack_q;
  assign PSG_BDIR   = bdir_q;
  assign PSG_BC     = bc_q;
  assign PSG_DO     = do_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;
  assign SEL_SHADOW = sel_q;

endmodule
